// File: rtl/labs_energy_eval.sv
// LABS energy evaluator: accepts one candidate sequence and computes the saturated
// sum of squared aperiodic autocorrelations, one lag per clock.
module labs_energy_eval #(
   parameter int SEQ_WIDTH = 16,
   parameter int E_WIDTH   = 16
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SEQ_WIDTH-1:0] in_seq,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SEQ_WIDTH-1:0] out_seq,
   output logic [E_WIDTH-1:0]   out_energy,
   output logic                 out_overflow
);

   localparam int K_W   = $clog2(SEQ_WIDTH);
   localparam int CW    = $clog2(SEQ_WIDTH + 1);
   localparam int SQ_W  = 2 * CW;
   localparam int SUM_W = ((E_WIDTH > SQ_W) ? E_WIDTH : SQ_W) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t               state_q, state_d;
   logic [SEQ_WIDTH-1:0] seq_q, seq_d;
   logic [K_W-1:0]       k_q, k_d;
   logic [E_WIDTH-1:0]   acc_q, acc_d;
   logic                 ovf_q, ovf_d;

   logic [SEQ_WIDTH-1:0] diff;
   logic [CW-1:0]        d_cnt;
   logic [CW-1:0]        n_minus_k;
   logic [CW-1:0]        agree;
   logic [CW-1:0]        abs_c;
   logic [SQ_W-1:0]      c_sq;
   logic [SUM_W-1:0]     sum;
   logic [SUM_W-1:0]     e_max;
   logic                 last_lag;

   // |C_k| = |agreements - disagreements| over the N-k overlapping pairs at lag k.
   always_comb begin
      diff  = (seq_q ^ (seq_q >> k_q)) & ({SEQ_WIDTH{1'b1}} >> k_q);
      // NOTE: blocking assignments here because d_cnt is a running sum within one evaluation.
      d_cnt = '0;
      for (int i = 0; i < SEQ_WIDTH; i++) begin
         d_cnt = d_cnt + CW'(diff[i]);
      end
      n_minus_k = CW'(SEQ_WIDTH) - CW'(k_q);
      agree     = n_minus_k - d_cnt;
      abs_c     = (agree >= d_cnt) ? (agree - d_cnt) : (d_cnt - agree);
      c_sq      = SQ_W'(abs_c) * SQ_W'(abs_c);
      sum       = SUM_W'(acc_q) + SUM_W'(c_sq);
   end

   assign e_max    = SUM_W'({E_WIDTH{1'b1}});
   assign last_lag = (k_q == K_W'(SEQ_WIDTH - 1));

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_d   = state_q;
      seq_d     = seq_q;
      k_d       = k_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               seq_d   = in_seq;
               k_d     = K_W'(1);
               acc_d   = '0;
               ovf_d   = 1'b0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (sum > e_max) begin
               acc_d = '1;
               ovf_d = 1'b1;
            end else begin
               acc_d = sum[E_WIDTH-1:0];
            end
            k_d = k_q + K_W'(1);
            if (last_lag) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: every register is reset here, including the datapath, because they drive outputs directly.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         seq_q   <= '0;
         k_q     <= K_W'(1);
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         seq_q   <= seq_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_seq      = seq_q;
   assign out_energy   = acc_q;
   assign out_overflow = ovf_q;

endmodule

// File: tb/tb_labs_energy_eval.sv
// Self-checking bench for labs_energy_eval: four instances of different widths,
// a vector table, handshake corner sequences and randomized runs against an energy model.
module tb_labs_energy_eval;

   localparam int NU = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [NU-1:0] iv, ir, ov, ordy, oo;
   logic [31:0]   is [NU];
   logic [31:0]   os [NU];
   logic [31:0]   oe [NU];

   logic [15:0] s0, s3;
   logic [3:0]  s1;
   logic [12:0] s2;
   logic [15:0] e0, e1, e2;
   logic [9:0]  e3;

   int n_checks = 0;
   int n_errors = 0;

   labs_energy_eval #(.SEQ_WIDTH(16), .E_WIDTH(16)) u_n16 (
      .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_seq(is[0][15:0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_seq(s0), .out_energy(e0), .out_overflow(oo[0]));
   labs_energy_eval #(.SEQ_WIDTH(4), .E_WIDTH(16)) u_n4 (
      .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_seq(is[1][3:0]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_seq(s1), .out_energy(e1), .out_overflow(oo[1]));
   labs_energy_eval #(.SEQ_WIDTH(13), .E_WIDTH(16)) u_n13 (
      .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_seq(is[2][12:0]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .out_seq(s2), .out_energy(e2), .out_overflow(oo[2]));
   labs_energy_eval #(.SEQ_WIDTH(16), .E_WIDTH(10)) u_sat (
      .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_seq(is[3][15:0]),
      .out_valid(ov[3]), .out_ready(ordy[3]), .out_seq(s3), .out_energy(e3), .out_overflow(oo[3]));

   assign os[0] = 32'(s0);
   assign os[1] = 32'(s1);
   assign os[2] = 32'(s2);
   assign os[3] = 32'(s3);
   assign oe[0] = 32'(e0);
   assign oe[1] = 32'(e1);
   assign oe[2] = 32'(e2);
   assign oe[3] = 32'(e3);

   typedef struct {
      int          unit;
      logic [31:0] seq;
      int          energy;
      bit          ovf;
   } vec_t;

   function automatic int nw(input int u);
      case (u)
         1:       return 4;
         2:       return 13;
         default: return 16;
      endcase
   endfunction

   function automatic int ew(input int u);
      return (u == 3) ? 10 : 16;
   endfunction

   function automatic logic [31:0] mask(input int n);
      return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
   endfunction

   // Energy straight from the definition: C_k = sum of s_i*s_(i+k) with s = +1/-1.
   function automatic void model(input logic [31:0] s, input int n, input int e_w,
                                 output int e, output bit o);
      int tot, c, lim;
      tot = 0;
      for (int k = 1; k < n; k++) begin
         c = 0;
         for (int i = 0; i + k < n; i++) c += (s[i] == s[i+k]) ? 1 : -1;
         tot += c * c;
      end
      lim = (1 << e_w) - 1;
      o   = (tot > lim);
      e   = o ? lim : tot;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic wait_idle(input int u, input string tag);
      int w;
      w = 0;
      while (!ir[u] && w < 64) begin
         @(negedge clk);
         w++;
      end
      check({tag, " in_ready idle"}, 32'(ir[u]), 32'd1);
   endtask

   // One full evaluation: accept, latency, result, single-cycle drain.
   task automatic run(input int u, input logic [31:0] s, input int exp_e, input bit exp_o,
                      input string tag);
      int lat;
      wait_idle(u, tag);
      iv[u] = 1'b1;
      is[u] = s;
      @(negedge clk);
      iv[u] = 1'b0;
      is[u] = $urandom;
      lat   = 0;
      while (!ov[u] && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(nw(u) - 1));
      check({tag, " out_seq"}, os[u], s & mask(nw(u)));
      check({tag, " out_energy"}, oe[u], 32'(exp_e));
      check({tag, " out_overflow"}, 32'(oo[u]), 32'(exp_o));
      ordy[u] = 1'b1;
      @(negedge clk);
      ordy[u] = 1'b0;
      check({tag, " out_valid drop"}, 32'(ov[u]), 32'd0);
      check({tag, " in_ready back"}, 32'(ir[u]), 32'd1);
   endtask

   vec_t vecs[14];

   initial begin
      int  acc_t[2];
      int  out_t[2];
      int  nacc, nout, u, me;
      bit  accepted, mo;
      logic [31:0] s;
      logic [15:0] bp_seq;

      rst  = 1'b1;
      iv   = '0;
      ordy = '0;
      for (int i = 0; i < NU; i++) is[i] = '0;

      vecs[0]  = '{1, 32'b0001, 2, 1'b0};
      vecs[1]  = '{1, 32'b1000, 2, 1'b0};
      vecs[2]  = '{1, 32'b1111, 14, 1'b0};
      vecs[3]  = '{2, 32'b1010110011111, 6, 1'b0};
      vecs[4]  = '{2, 32'b0101001100000, 6, 1'b0};
      vecs[5]  = '{0, 32'hFFFF, 1240, 1'b0};
      vecs[6]  = '{0, 32'h5555, 1240, 1'b0};
      vecs[7]  = '{0, 32'hAAAA, 1240, 1'b0};
      vecs[8]  = '{0, 32'h00FF, 568, 1'b0};
      vecs[9]  = '{0, 32'hFF00, 568, 1'b0};
      vecs[10] = '{0, 32'h0001, 820, 1'b0};
      vecs[11] = '{3, 32'h0000, 1023, 1'b1};
      vecs[12] = '{3, 32'hFFFF, 1023, 1'b1};
      vecs[13] = '{3, 32'h00FF, 568, 1'b0};

      repeat (2) @(negedge clk);
      for (int i = 0; i < NU; i++) begin
         check($sformatf("reset u%0d in_ready", i), 32'(ir[i]), 32'd1);
         check($sformatf("reset u%0d out_valid", i), 32'(ov[i]), 32'd0);
         check($sformatf("reset u%0d out_seq", i), os[i], 32'd0);
         check($sformatf("reset u%0d out_energy", i), oe[i], 32'd0);
         check($sformatf("reset u%0d out_overflow", i), 32'(oo[i]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 14; i++)
         run(vecs[i].unit, vecs[i].seq, vecs[i].energy, vecs[i].ovf, $sformatf("vec%0d", i));

      // Back-to-back FFFF then 5555 with out_ready held high.
      wait_idle(0, "b2b");
      ordy[0] = 1'b1;
      is[0]   = 32'hFFFF;
      iv[0]   = 1'b1;
      nacc    = 0;
      nout    = 0;
      acc_t   = '{0, 0};
      out_t   = '{0, 0};
      for (int c = 0; c < 100 && nout < 2; c++) begin
         accepted = iv[0] && ir[0];
         if (accepted && nacc < 2) begin
            acc_t[nacc] = c;
            nacc++;
         end
         if (ov[0]) begin
            out_t[nout] = c;
            check("b2b out_energy", oe[0], 32'd1240);
            check("b2b out_overflow", 32'(oo[0]), 32'd0);
            check("b2b in_ready in DONE", 32'(ir[0]), 32'd0);
            check("b2b out_seq", os[0], (nout == 0) ? 32'hFFFF : 32'h5555);
            nout++;
         end
         @(negedge clk);
         if (accepted) begin
            if (nacc == 1) is[0] = 32'h5555;
            else           iv[0] = 1'b0;
         end
      end
      iv[0]   = 1'b0;
      ordy[0] = 1'b0;
      check("b2b results seen", 32'(nout), 32'd2);
      check("b2b accept spacing", 32'(acc_t[1] - acc_t[0]), 32'd17);
      check("b2b out_valid spacing", 32'(out_t[1] - out_t[0]), 32'd17);
      check("b2b first latency", 32'(out_t[0] - acc_t[0]), 32'd16);
      @(negedge clk);

      // Backpressure: 20 stalled cycles with stray input pulses.
      bp_seq = 16'h00FF;
      wait_idle(0, "bp");
      iv[0] = 1'b1;
      is[0] = 32'(bp_seq);
      @(negedge clk);
      iv[0] = 1'b0;
      for (int w = 0; w < 64 && !ov[0]; w++) @(negedge clk);
      for (int c = 0; c < 20; c++) begin
         check("bp out_valid held", 32'(ov[0]), 32'd1);
         check("bp in_ready low", 32'(ir[0]), 32'd0);
         check("bp out_seq stable", os[0], 32'(bp_seq));
         check("bp out_energy stable", oe[0], 32'd568);
         check("bp out_overflow stable", 32'(oo[0]), 32'd0);
         iv[0] = c[0];
         is[0] = $urandom;
         @(negedge clk);
      end
      iv[0]   = 1'b0;
      ordy[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b0;
      check("bp out_valid fall", 32'(ov[0]), 32'd0);
      check("bp in_ready rise", 32'(ir[0]), 32'd1);
      repeat (3) @(negedge clk);
      check("bp no stray accept", 32'(ir[0]), 32'd1);
      check("bp no stray result", 32'(ov[0]), 32'd0);

      // Asynchronous reset while lag 5 is being computed.
      wait_idle(0, "rst");
      iv[0] = 1'b1;
      is[0] = 32'h0000;
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst mid-calc out_valid", 32'(ov[0]), 32'd0);
      check("rst mid-calc in_ready", 32'(ir[0]), 32'd1);
      check("rst mid-calc out_energy", oe[0], 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run(0, 32'h00FF, 568, 1'b0, "post-rst");

      for (int i = 0; i < 40; i++) begin
         u = $urandom_range(0, NU - 1);
         s = $urandom;
         model(s, nw(u), ew(u), me, mo);
         run(u, s, me, mo, $sformatf("rand%0d u%0d", i, u));
      end

      for (int i = 0; i < 6; i++) begin
         u = (i % 2 == 0) ? 2 : 3;
         s = $urandom;
         model(s, nw(u), ew(u), me, mo);
         run(u, s, me, mo, $sformatf("cmpl%0d a", i));
         model(~s, nw(u), ew(u), me, mo);
         run(u, ~s, me, mo, $sformatf("cmpl%0d b", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/labs_energy_eval.md
Name: labs_energy_eval

Overview:
- Sequential energy evaluator for the low-autocorrelation binary sequence (LABS) search.
- Sits directly upstream of the Wishbone search core. It accepts one candidate sequence and computes E = sum_{k=1..N-1} C_k^2.
- Hands {sequence, energy} to the search core's best-result tracking over a valid/ready handshake.
- One instance per parallel unit. One autocorrelation lag is processed per clock.

Parameters:
- SEQ_WIDTH, 16, sequence length N in bits (legal range 3..32).
- E_WIDTH, 16, energy output width. The accumulator saturates at 2^E_WIDTH-1.

Ports:
- wb_clk_i  input  1  clock; all state changes on the rising edge.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- in_valid  input  1  candidate sequence valid.
- in_ready  output  1  block can accept a candidate.
- in_seq  input  SEQ_WIDTH  candidate; bit i maps to s_i = +1 if 1, -1 if 0.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_seq  output  SEQ_WIDTH  sequence the result belongs to.
- out_energy  output  E_WIDTH  computed energy, saturated.
- out_overflow  output  1  saturation occurred during this evaluation.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_seq=0, out_energy=0, out_overflow=0, lag counter k=1, accumulator=0.
- FSM states are IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_seq, set k=1, acc=0, ovf=0, go to CALC.
  - With in_valid=0: stay in IDLE.
- CALC:
  - in_ready=0, out_valid=0.
  - Each cycle:
    - d = popcount((seq ^ (seq >> k)) & mask_k), where mask_k has ones in bits 0..N-1-k.
    - C_k = (N-k) - 2d, signed.
    - acc <= sat(acc + C_k^2).
    - k <= k+1.
  - On the cycle where k==N-1, the final term is accumulated and the next state is DONE.
  - The squaring uses an unsigned |C_k|. Internal width is at least E_WIDTH+1, so the overflow can be detected.
  - Saturation: if acc + C_k^2 > 2^E_WIDTH-1, acc <= 2^E_WIDTH-1 and ovf <= 1. Once saturated, acc stays saturated.
- DONE:
  - out_valid=1; out_seq, out_energy and out_overflow hold the latched values.
  - All outputs stay stable while out_ready=0. Backpressure is unbounded.
  - On out_valid&out_ready: go to IDLE, out_valid=0. out_* keep their last values; they are don't-care while out_valid=0.
  - in_ready=0 in DONE. An input presented in DONE is not accepted until IDLE.
- Latency: the accept edge is at cycle T. out_valid rises at T+N-1, after N-1 CALC cycles.
- Throughput: one sequence per N+1 cycles when out_ready=1 continuously.
- The input handshake follows the standard valid/ready rule: the transfer happens only on the edge where both are high. in_seq is sampled only at that edge; later changes have no effect.
- Reset mid-CALC or mid-DONE aborts the evaluation, and no result is emitted.
- Energy is invariant to bit reversal and complement. Evaluating a sequence and its complement must give identical out_energy.

Test Plan:
- SEQ_WIDTH=4, in_seq=4'b0001 -> out_energy=2, out_overflow=0, out_valid exactly 3 cycles after accept, out_seq=4'b0001.
- SEQ_WIDTH=13, in_seq=13'b1010110011111 (Barker-13) -> out_energy=6. Its complement 13'b0101001100000 -> also 6.
- SEQ_WIDTH=16, in_seq=16'hFFFF, then 16'h5555 -> out_energy=1240 for each, out_overflow=0. Issue them back to back with out_ready=1 and check in_ready and out_valid spacing of 17 cycles.
- SEQ_WIDTH=16, E_WIDTH=10, in_seq=16'h0000 -> out_energy=1023, out_overflow=1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_* stable, in_ready=0, input pulses ignored. Then raise out_ready for 1 cycle -> out_valid falls and in_ready=1 the next cycle.
- Assert wb_rst_i asynchronously mid-CALC (k=5) -> out_valid=0 and in_ready=1 immediately. A subsequent new sequence evaluates correctly with no residue in the accumulator.
